// File: rtl/requantizer.sv
// -----------------------------------------------------------------------------
// requantizer
//
// Multi-lane requantization stage. Converts signed ACC_WIDTH accumulators from
// the PE array into signed DATA_WIDTH activations. Each lane applies these
// steps in order:
//   1. multiply by a per-lane unsigned scale
//   2. rounding arithmetic right shift (round half up)
//   3. optional ReLU
//   4. add a signed zero point
//   5. saturate to the output range
// With the reset configuration (scale 1, shift 0, zp 0, ReLU off) the result is
// plain saturating narrowing.
//
// Pipeline (three register stages, full back-pressure, no skid buffer):
//   S1 : multiply               (captures per-beat shift / zp / relu)
//   S2 : round, shift, ReLU
//   S3 : zero-point add, saturate -> out_data / out_sat / out_valid
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input beat handshake
//   in_data               LANES x ACC_WIDTH signed; lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   relu_en               per-beat ReLU enable, sampled with the beat
//   out_valid / out_ready output beat handshake
//   out_data              LANES x DATA_WIDTH signed, same packing as in_data
//   out_sat               per-lane "clamped" flag for the current output beat
//   cfg_we, cfg_lane      configuration write strobe and target lane
//   cfg_scale/shift/zp    per-lane scale (unsigned), shift, zero point (signed)
//   sat_clr               clears sat_sticky (wins over a same-cycle set)
//   sat_sticky            per-lane OR of out_sat over output handshakes
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

module requantizer #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int ACC_WIDTH   = `ACC_WIDTH,
  parameter int LANES       = 4,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 6,
  localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*ACC_WIDTH-1:0]  in_data,
  input  logic                        relu_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_sat,
  input  logic                        cfg_we,
  input  logic [LANE_W-1:0]           cfg_lane,
  input  logic [SCALE_WIDTH-1:0]      cfg_scale,
  input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
  input  logic [DATA_WIDTH-1:0]       cfg_zp,
  input  logic                        sat_clr,
  output logic [LANES-1:0]            sat_sticky
);

  // Product width: signed accumulator times zero-extended scale.
  localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;
  // One guard bit so adding the rounding constant can never overflow.
  localparam int RW = PW + 1;
  // One more bit for the zero-point add.
  localparam int ZW = RW + 1;

  localparam logic signed [ZW-1:0] ZMAX = ZW'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ZW-1:0] ZMIN = ~ZMAX;

  // ---------------------------------------------------------------------------
  // Stage valids and advance chain
  // ---------------------------------------------------------------------------
  logic v1_reg, v2_reg, v3_reg;
  logic adv1, adv2, adv3;
  logic relu1_reg;

  // A stage may load when it is empty or when its contents move on this cycle.
  // The chain is purely combinational back to in_ready.
  assign adv3      = ~v3_reg | out_ready;
  assign adv2      = ~v2_reg | adv3;
  assign adv1      = ~v1_reg | adv2;
  assign in_ready  = adv1;
  assign out_valid = v3_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      v3_reg    <= 1'b0;
      relu1_reg <= 1'b0;
    end else begin
      if (adv1) begin
        v1_reg <= in_valid;
      end
      if (adv2) begin
        v2_reg <= v1_reg;
      end
      if (adv3) begin
        v3_reg <= v2_reg;
      end
      if (adv1 && in_valid) begin
        relu1_reg <= relu_en;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane configuration and datapath
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // Configuration registers.
      logic        [SCALE_WIDTH-1:0] scale_reg;
      logic        [SHIFT_WIDTH-1:0] shift_reg;
      logic signed [DATA_WIDTH-1:0]  zp_reg;

      // S1 state: product plus the beat's own shift / zp copies.
      logic signed [PW-1:0]          p1_reg;
      logic        [SHIFT_WIDTH-1:0] shift1_reg;
      logic signed [DATA_WIDTH-1:0]  zp1_reg;

      // S2 state: rounded and ReLU'd value.
      logic signed [RW-1:0]          r2_reg;
      logic signed [DATA_WIDTH-1:0]  zp2_reg;

      // S3 state: lane output.
      logic        [DATA_WIDTH-1:0]  od_reg;
      logic                          os_reg;

      // Combinational stage results.
      logic signed [PW-1:0]          acc_ext;
      logic signed [PW-1:0]          scale_ext;
      logic signed [PW-1:0]          prod;
      logic signed [RW-1:0]          p_ext;
      logic signed [RW-1:0]          rnd;
      logic signed [RW-1:0]          sum;
      logic signed [RW-1:0]          shifted;
      logic signed [RW-1:0]          r_next;
      logic signed [ZW-1:0]          z;
      logic                          sat_hi;
      logic                          sat_lo;
      logic        [DATA_WIDTH-1:0]  od_next;

      // Configuration write. A write lands on the same edge that may accept a
      // beat; that beat samples the old register values, so the new values
      // only reach beats accepted afterwards.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          scale_reg <= SCALE_WIDTH'(1);
          shift_reg <= '0;
          zp_reg    <= '0;
        end else if (cfg_we && (cfg_lane == LANE_W'(gi))) begin
          scale_reg <= cfg_scale;
          shift_reg <= cfg_shift;
          zp_reg    <= cfg_zp;
        end
      end

      // S1: signed accumulator times zero-extended scale.
      always_comb begin
        acc_ext   = PW'($signed(in_data[gi*ACC_WIDTH +: ACC_WIDTH]));
        scale_ext = PW'(scale_reg);
        prod      = acc_ext * scale_ext;
      end

      // S2: round-half-up arithmetic shift, then ReLU.
      // Shifts of PW or more always collapse to 0 (even -1 ties round up), so
      // they are forced directly rather than building a wider rounding term.
      always_comb begin
        p_ext   = RW'(p1_reg);
        rnd     = RW'(1) << (shift1_reg - SHIFT_WIDTH'(1));
        sum     = p_ext + rnd;
        shifted = sum >>> shift1_reg;
        if (shift1_reg == '0) begin
          r_next = p_ext;
        end else if (32'(shift1_reg) >= PW) begin
          r_next = '0;
        end else begin
          r_next = shifted;
        end
        if (relu1_reg && r_next[RW-1]) begin
          r_next = '0;
        end
      end

      // S3: zero-point add at full width, then clamp to the output range.
      always_comb begin
        z      = ZW'(r2_reg) + ZW'(zp2_reg);
        sat_hi = (z > ZMAX);
        sat_lo = (z < ZMIN);
        if (sat_hi) begin
          od_next = ZMAX[DATA_WIDTH-1:0];
        end else if (sat_lo) begin
          od_next = ZMIN[DATA_WIDTH-1:0];
        end else begin
          od_next = z[DATA_WIDTH-1:0];
        end
      end

      // Stage registers only load when their upstream stage holds a beat, so
      // out_data / out_sat stay put during stalls and bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p1_reg     <= '0;
          shift1_reg <= '0;
          zp1_reg    <= '0;
          r2_reg     <= '0;
          zp2_reg    <= '0;
          od_reg     <= '0;
          os_reg     <= 1'b0;
        end else begin
          if (adv1 && in_valid) begin
            p1_reg     <= prod;
            shift1_reg <= shift_reg;
            zp1_reg    <= zp_reg;
          end
          if (adv2 && v1_reg) begin
            r2_reg  <= r_next;
            zp2_reg <= zp1_reg;
          end
          if (adv3 && v2_reg) begin
            od_reg <= od_next;
            os_reg <= sat_hi | sat_lo;
          end
        end
      end

      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = od_reg;
      assign out_sat[gi]                           = os_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sticky saturation flags. A clear wins over a same-cycle handshake, so that
  // beat's flags are dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= '0;
    end else if (sat_clr) begin
      sat_sticky <= '0;
    end else if (v3_reg && out_ready) begin
      sat_sticky <= sat_sticky | out_sat;
    end
  end

endmodule

// File: tb/tb_requantizer.sv
// -----------------------------------------------------------------------------
// tb_requantizer
//
// Directed bench for requantizer. A behavioural model computes each beat's
// expected lanes from the arithmetic rules (64-bit integer math) when the beat
// is accepted; a single compare process checks outputs, stall stability,
// in_ready and sat_sticky every cycle. Directed sections add hand-computed
// literal checks on the logged output beats.
// -----------------------------------------------------------------------------
module tb_requantizer;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int L  = 4;
  localparam int SW = 16;
  localparam int HW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [L*AW-1:0]   in_data;
  logic              relu_en;
  logic              out_valid;
  logic              out_ready;
  logic [L*DW-1:0]   out_data;
  logic [L-1:0]      out_sat;
  logic              cfg_we;
  logic [1:0]        cfg_lane;
  logic [SW-1:0]     cfg_scale;
  logic [HW-1:0]     cfg_shift;
  logic [DW-1:0]     cfg_zp;
  logic              sat_clr;
  logic [L-1:0]      sat_sticky;

  always #5 clk = ~clk;

  requantizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .relu_en    (relu_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .cfg_we     (cfg_we),
    .cfg_lane   (cfg_lane),
    .cfg_scale  (cfg_scale),
    .cfg_shift  (cfg_shift),
    .cfg_zp     (cfg_zp),
    .sat_clr    (sat_clr),
    .sat_sticky (sat_sticky)
  );

  typedef struct {
    logic [L*DW-1:0] data;
    logic [L-1:0]    sat;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       out_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_scale[L];
  int          m_shift[L];
  int          m_zp[L];
  logic [L-1:0] m_sticky;
  bit          stall_prev;
  logic [L*DW-1:0] held_data;
  logic [L-1:0]    held_sat;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for one lane.
  function automatic void lane_model(input longint acc, input longint scale,
                                     input int shift, input longint zp,
                                     input bit relu, output int y, output bit s);
    longint p, r, z;
    p = acc * scale;
    if (shift == 0) r = p;
    else            r = (p + (longint'(1) <<< (shift - 1))) >>> shift;
    if (relu && r < 0) r = 0;
    z = r + zp;
    if (z > 127)       begin y = 127;    s = 1'b1; end
    else if (z < -128) begin y = -128;   s = 1'b1; end
    else               begin y = int'(z); s = 1'b0; end
  endfunction

  function automatic beat_t model_beat(input logic [L*AW-1:0] d, input bit relu);
    beat_t  b;
    int     y;
    bit     s;
    longint acc;
    for (int i = 0; i < L; i++) begin
      acc = longint'($signed(d[i*AW +: AW]));
      lane_model(acc, longint'(m_scale[i]), m_shift[i], longint'(m_zp[i]), relu, y, s);
      b.data[i*DW +: DW] = y[DW-1:0];
      b.sat[i]           = s;
    end
    return b;
  endfunction

  function automatic logic [L*AW-1:0] pack(input int a0, input int a1,
                                           input int a2, input int a3);
    logic [L*AW-1:0] r;
    r[0*AW +: AW] = a0;
    r[1*AW +: AW] = a1;
    r[2*AW +: AW] = a2;
    r[3*AW +: AW] = a3;
    return r;
  endfunction

  function automatic int lane_of(input logic [L*DW-1:0] d, input int i);
    logic signed [DW-1:0] t;
    t = d[i*DW +: DW];
    return int'(t);
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: everything is sampled on the falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_sticky", sat_sticky, 0);
      exp_q.delete();
      for (int i = 0; i < L; i++) begin
        m_scale[i] = 1;
        m_shift[i] = 0;
        m_zp[i]    = 0;
      end
      m_sticky   = '0;
      stall_prev = 1'b0;
    end else begin
      // All three stages full and downstream stalled is the only way in_ready drops.
      chk("in_ready", in_ready, !(exp_q.size() == 3 && !out_ready));
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_data);
        chk("stall_sat", out_sat, held_sat);
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_sat   = out_sat;
      chk("sticky", sat_sticky, m_sticky);
      if (out_valid && out_ready) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_sat", out_sat, e.sat);
          out_log.push_back(e);
          if (sat_clr) m_sticky = '0;
          else         m_sticky = m_sticky | e.sat;
        end
      end else if (sat_clr) begin
        m_sticky = '0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_beat(in_data, relu_en));
      end
      if (cfg_we) begin
        m_scale[cfg_lane] = int'(cfg_scale);
        m_shift[cfg_lane] = int'(cfg_shift);
        m_zp[cfg_lane]    = int'($signed(cfg_zp));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic send(input logic [L*AW-1:0] d, input bit r);
    bit ok;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    relu_en  = r;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) done = 1'b1;
    end
    #1;
    in_valid = 1'b0;
    relu_en  = 1'b0;
    if (!done) chk("send_accept", done, 1);
  endtask

  task automatic cfg_write(input int lane, input int scale, input int shift, input int zp);
    cfg_we    = 1'b1;
    cfg_lane  = 2'(lane);
    cfg_scale = SW'(scale);
    cfg_shift = HW'(shift);
    cfg_zp    = DW'(zp);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lane(input string nm, input int idx, input int lane, input int exp);
    if (idx < out_log.size()) chk(nm, lane_of(out_log[idx].data, lane), exp);
    else                      chk({nm, "_missing"}, out_log.size(), idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int y;
    bit s;
    int k;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_lane  = '0;
    cfg_scale = '0;
    cfg_shift = '0;
    cfg_zp    = '0;
    sat_clr   = 1'b0;

    // Pin the model against hand-computed values.
    lane_model(300, 1, 0, 0, 0, y, s);   chk("model_300", y, 127);  chk("model_300_sat", s, 1);
    lane_model(-6, 3, 2, 0, 0, y, s);    chk("model_rnd_neg", y, -4);
    lane_model(5, 3, 2, 0, 0, y, s);     chk("model_rnd_pos", y, 4);
    lane_model(-50, 1, 0, -10, 1, y, s); chk("model_relu_zp", y, -10);
    lane_model(-7, 1, 50, 5, 0, y, s);   chk("model_bigshift", y, 5);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset defaults and latency.
    out_log.delete();
    send(pack(300, -300, 127, -128), 0);
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("latency", k, 3);
    drain();
    chk_lane("t1_l0", 0, 0, 127);
    chk_lane("t1_l1", 0, 1, -128);
    chk_lane("t1_l2", 0, 2, 127);
    chk_lane("t1_l3", 0, 3, -128);
    if (out_log.size() > 0) chk("t1_sat", out_log[0].sat, 4'b0011);

    // Scale, shift and rounding; oversize shift.
    cfg_write(0, 3, 2, 0);
    out_log.delete();
    send(pack(5, 0, 0, 0), 0);
    send(pack(-6, 0, 0, 0), 0);
    send(pack(2, 0, 0, 0), 0);
    drain();
    chk_lane("rnd_5", 0, 0, 4);
    chk_lane("rnd_m6", 1, 0, -4);
    chk_lane("rnd_2", 2, 0, 2);
    cfg_write(0, 1, 50, 5);
    out_log.delete();
    send(pack(-7, 0, 0, 0), 0);
    drain();
    chk_lane("bigshift", 0, 0, 5);

    // ReLU and zero point.
    cfg_write(0, 1, 0, -10);
    out_log.delete();
    send(pack(-50, 0, 0, 0), 1);
    send(pack(-50, 0, 0, 0), 0);
    cfg_write(0, 1, 0, 100);
    send(pack(50, 0, 0, 0), 0);
    drain();
    chk_lane("relu_on", 0, 0, -10);
    chk_lane("relu_off", 1, 0, -60);
    chk_lane("zp_clamp", 2, 0, 127);
    if (out_log.size() > 2) chk("zp_clamp_sat", out_log[2].sat[0], 1);

    // Back-pressure: out_ready pattern 1,0,0 repeating.
    out_log.delete();
    fork
      begin
        for (int b = 0; b < 8; b++) send(pack(b * 10, -b, b, 100 * b), 0);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = (c % 3 == 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", out_log.size(), 8);
    chk_lane("bp_last", 7, 1, -7);

    // Configuration race on lane 1.
    out_log.delete();
    cfg_we    = 1'b1;
    cfg_lane  = 2'd1;
    cfg_scale = SW'(2);
    cfg_shift = '0;
    cfg_zp    = '0;
    in_valid  = 1'b1;
    in_data   = pack(0, 10, 0, 0);
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
    in_data = pack(0, 11, 0, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_write(1, 5, 0, 0);
    drain();
    chk_lane("race_old", 0, 1, 10);
    chk_lane("race_new", 1, 1, 22);

    // Sticky flags with clear racing a saturating handshake.
    out_log.delete();
    send(pack(0, 0, 1000, 0), 0);
    drain();
    chk("sticky_set", sat_sticky[2], 1);
    send(pack(0, 0, -1000, 0), 0);
    repeat (2) @(posedge clk);
    #1 sat_clr = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    chk("sticky_clr", sat_sticky, 0);
    chk("sticky_beats", out_log.size(), 2);
    if (out_log.size() > 1) chk("sticky_beat_sat", out_log[1].sat[2], 1);

    // Reset asserted mid-stall.
    cfg_write(0, 3, 0, 0);
    out_ready = 1'b0;
    send(pack(1, 0, 0, 0), 0);
    send(pack(2, 0, 0, 0), 0);
    send(pack(3, 0, 0, 0), 0);
    @(posedge clk);
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_log.delete();
    send(pack(7, 0, 0, 0), 0);
    drain();
    chk_lane("post_rst_identity", 0, 0, 7);
    chk("post_rst_count", out_log.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
